itlb_ptw: RTL and testbench

ITLB_PTW -- requirements
Module: itlb_ptw

---
 rtl/itlb_ptw.sv | 176 +++++++++++++++++
 tb/tb_itlb_ptw.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/itlb_ptw.sv
// Sv32 instruction-side page-table walker feeding the ITLB.
// On an ITLB miss it reads the level-1 PTE and, for pointer PTEs, the level-0
// PTE, then either writes one ITLB entry (round-robin victim) or pulses an
// instruction page fault. Every output is registered.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   miss_i, vpn_i       ITLB miss request and the VPN that missed
//   satp_ppn            root page-table PPN
//   mem_req, mem_addr   PTE read request and byte address (held until mem_ack)
//   mem_ack, mem_rdata  read completion with PTE data in the same cycle
//   tlb_we, tlb_waddr,
//   tlb_wdata           one-cycle ITLB write {VPN, PTE}
//   busy                walk in progress
//   fault, fault_vpn    one-cycle page-fault pulse and VPN of the last fault
module itlb_ptw #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned PA_W    = 34
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss_i,
    input  logic [19:0]                 vpn_i,
    input  logic [21:0]                 satp_ppn,
    output logic                        mem_req,
    output logic [PA_W-1:0]             mem_addr,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata,
    output logic                        tlb_we,
    output logic [$clog2(ENTRIES)-1:0]  tlb_waddr,
    output logic [51:0]                 tlb_wdata,
    output logic                        busy,
    output logic                        fault,
    output logic [19:0]                 fault_vpn
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {IDLE, L1, L0, FILL, FAULT} state_t;

    state_t             state, state_d;
    logic [19:0]        vpn_q, vpn_d;
    logic [IDX_W-1:0]   victim, victim_d;

    logic               mem_req_d;
    logic [PA_W-1:0]    mem_addr_d;
    logic               tlb_we_d;
    logic [IDX_W-1:0]   tlb_waddr_d;
    logic [51:0]        tlb_wdata_d;
    logic               busy_d;
    logic               fault_d;
    logic [19:0]        fault_vpn_d;

    // PTE decode of the word returned by memory
    logic pte_v, pte_r, pte_w, pte_x, pte_a;
    logic pte_leaf, pte_bad, leaf_noperm, super_misaligned;
    logic [31:0] super_pte;

    assign pte_v            = mem_rdata[0];
    assign pte_r            = mem_rdata[1];
    assign pte_w            = mem_rdata[2];
    assign pte_x            = mem_rdata[3];
    assign pte_a            = mem_rdata[6];
    assign pte_leaf         = pte_r | pte_x;
    assign pte_bad          = ~pte_v | (~pte_r & pte_w);
    // No hardware A/D update, so an unexecutable or unaccessed leaf faults
    assign leaf_noperm      = ~pte_x | ~pte_a;
    assign super_misaligned = |mem_rdata[19:10];
    // A 4 MiB superpage supplies PPN[0] from the VPN so the entry maps 4 KiB
    assign super_pte        = {mem_rdata[31:20], vpn_q[9:0], mem_rdata[9:0]};

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        vpn_d       = vpn_q;
        victim_d    = victim;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        tlb_we_d    = 1'b0;
        tlb_waddr_d = tlb_waddr;
        tlb_wdata_d = tlb_wdata;
        busy_d      = busy;
        fault_d     = 1'b0;
        fault_vpn_d = fault_vpn;

        case (state)
            IDLE: begin
                if (miss_i) begin
                    state_d    = L1;
                    vpn_d      = vpn_i;
                    mem_req_d  = 1'b1;
                    mem_addr_d = PA_W'({satp_ppn, vpn_i[19:10], 2'b00});
                    busy_d     = 1'b1;
                end
            end
            L1: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pte_bad || (pte_leaf && (super_misaligned || leaf_noperm))) begin
                        state_d     = FAULT;
                        fault_d     = 1'b1;
                        fault_vpn_d = vpn_q;
                    end else if (pte_leaf) begin
                        state_d     = FILL;
                        tlb_we_d    = 1'b1;
                        tlb_waddr_d = victim;
                        tlb_wdata_d = {vpn_q, super_pte};
                    end else begin
                        state_d    = L0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = PA_W'({mem_rdata[31:10], vpn_q[9:0], 2'b00});
                    end
                end
            end
            L0: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pte_bad || !pte_leaf || leaf_noperm) begin
                        state_d     = FAULT;
                        fault_d     = 1'b1;
                        fault_vpn_d = vpn_q;
                    end else begin
                        state_d     = FILL;
                        tlb_we_d    = 1'b1;
                        tlb_waddr_d = victim;
                        tlb_wdata_d = {vpn_q, mem_rdata};
                    end
                end
            end
            FILL: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                victim_d = (victim == IDX_W'(ENTRIES - 1)) ? '0 : victim + IDX_W'(1);
            end
            FAULT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vpn_q     <= '0;
            victim    <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            tlb_we    <= 1'b0;
            tlb_waddr <= '0;
            tlb_wdata <= '0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            fault_vpn <= '0;
        end else begin
            state     <= state_d;
            vpn_q     <= vpn_d;
            victim    <= victim_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            tlb_we    <= tlb_we_d;
            tlb_waddr <= tlb_waddr_d;
            tlb_wdata <= tlb_wdata_d;
            busy      <= busy_d;
            fault     <= fault_d;
            fault_vpn <= fault_vpn_d;
        end
    end

endmodule

// File: tb/tb_itlb_ptw.sv
// Self-checking bench for itlb_ptw: table of walks with hand-derived
// outcomes, a scoreboard for ITLB writes and faults, and directed sequences
// for mid-walk reset and victim-counter wrap.
module tb_itlb_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_i;
    logic [19:0] vpn_i;
    logic [21:0] satp_ppn;
    logic        mem_req;
    logic [33:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        tlb_we;
    logic [4:0]  tlb_waddr;
    logic [51:0] tlb_wdata;
    logic        busy;
    logic        fault;
    logic [19:0] fault_vpn;

    itlb_ptw #(.ENTRIES(32), .PA_W(34)) dut (
        .clk(clk), .rst(rst), .miss_i(miss_i), .vpn_i(vpn_i), .satp_ppn(satp_ppn),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .tlb_we(tlb_we), .tlb_waddr(tlb_waddr), .tlb_wdata(tlb_wdata),
        .busy(busy), .fault(fault), .fault_vpn(fault_vpn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] vpn;
        logic [21:0] satp;
        logic [31:0] l1;
        logic [31:0] l0;
        int          dly;
        bit          ack_with_miss;
        bit          exp_l0;
        bit          exp_fault;
        logic [31:0] exp_pte;
    } vec_t;

    typedef struct {
        bit          is_fault;
        logic [4:0]  waddr;
        logic [51:0] wdata;
        logic [19:0] fvpn;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [4:0] m_victim = '0;
    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: every tlb_we or fault pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (tlb_we || fault)) begin
            exp_t e;
            chk("we_fault_exclusive", 64'(tlb_we & fault), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'({tlb_we, fault}), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_kind", 64'({tlb_we, fault}), e.is_fault ? 64'b01 : 64'b10);
                if (e.is_fault) begin
                    chk("fault_vpn", 64'(fault_vpn), 64'(e.fvpn));
                end else begin
                    chk("tlb_waddr", 64'(tlb_waddr), 64'(e.waddr));
                    chk("tlb_wdata", 64'(tlb_wdata), 64'(e.wdata));
                end
            end
        end
    end

    // Hold a request for dly cycles checking stability, then acknowledge it
    task automatic serve(input string nm, input logic [33:0] a, input logic [31:0] d, input int dly);
        chk({nm, "_req"}, 64'(mem_req), 64'd1);
        chk({nm, "_addr"}, 64'(mem_addr), 64'(a));
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({nm, "_req_hold"}, 64'(mem_req), 64'd1);
            chk({nm, "_addr_hold"}, 64'(mem_addr), 64'(a));
        end
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic walk(input vec_t v, input bit hold);
        exp_t e;
        logic [33:0] a1, a0;
        a1 = {v.satp, v.vpn[19:10], 2'b00};
        a0 = {v.l1[31:10], v.vpn[9:0], 2'b00};
        e.is_fault = v.exp_fault;
        e.waddr    = m_victim;
        e.wdata    = {v.vpn, v.exp_pte};
        e.fvpn     = v.vpn;
        if (!v.exp_fault) m_victim = m_victim + 5'd1;
        sb.push_back(e);

        @(negedge clk);
        miss_i   = 1'b1;
        vpn_i    = v.vpn;
        satp_ppn = v.satp;
        if (v.ack_with_miss) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        if (!hold) miss_i = 1'b0;
        mem_ack = 1'b0;
        vpn_i   = ~v.vpn;
        chk("busy_walk", 64'(busy), 64'd1);
        serve("l1", a1, v.l1, v.dly);
        if (v.exp_l0) serve("l0", a0, v.l0, 0);
        else chk("no_l0_req", 64'(mem_req), 64'd0);
        chk("done_pulse", 64'(tlb_we | fault), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        miss_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_req", 64'(mem_req), 64'd0);
        chk("idle_quiet", 64'({tlb_we, fault}), 64'd0);
    endtask

    initial begin
        //          vpn        satp    l1            l0            dly awm l0 flt exp_pte
        vecs[0]  = '{20'h00403, 22'h1,  32'h00000801, 32'h0001404B, 0, 0, 1, 0, 32'h0001404B};
        vecs[1]  = '{20'h00403, 22'h1,  32'h0040004B, 32'h0,        0, 0, 0, 0, 32'h00400C4B};
        vecs[2]  = '{20'h00403, 22'h1,  32'h0040044B, 32'h0,        0, 0, 0, 1, 32'h0};
        vecs[3]  = '{20'h00403, 22'h1,  32'h00000000, 32'h0,        1, 0, 0, 1, 32'h0};
        vecs[4]  = '{20'h00403, 22'h1,  32'h00000005, 32'h0,        0, 0, 0, 1, 32'h0};
        vecs[5]  = '{20'h00403, 22'h1,  32'h00000801, 32'h00014043, 0, 0, 1, 1, 32'h0};
        vecs[6]  = '{20'h00403, 22'h1,  32'h00000801, 32'h0001400B, 2, 0, 1, 1, 32'h0};
        vecs[7]  = '{20'hABCDE, 22'h3FFFFF, 32'h12345C01, 32'h0ABCD0CF, 0, 1, 1, 0, 32'h0ABCD0CF};
        vecs[8]  = '{20'h00403, 22'h1,  32'h00000801, 32'h0001404D, 0, 0, 1, 1, 32'h0};
        vecs[9]  = '{20'h12345, 22'h10, 32'h00400049, 32'h0,        0, 0, 0, 0, 32'h004D1449};
        vecs[10] = '{20'h00403, 22'h1,  32'h00000801, 32'h00014001, 1, 0, 1, 1, 32'h0};

        rst = 1'b1; miss_i = 1'b0; vpn_i = '0; satp_ppn = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({mem_req, tlb_we, busy, fault}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'({tlb_waddr, tlb_wdata}), 64'd0);
        chk("rst_fault_vpn", 64'(fault_vpn), 64'd0);
        rst = 1'b0;

        // Literal spec addresses for the first walk
        vpn_i = 20'h00403; satp_ppn = 22'h1;
        chk("spec_l1_addr", 64'({satp_ppn, vpn_i[19:10], 2'b00}), 64'h1004);

        for (int i = 0; i < 11; i++) walk(vecs[i], 1'b0);

        // Reset while the L0 request is outstanding abandons the walk
        @(negedge clk);
        miss_i = 1'b1; vpn_i = 20'h00403; satp_ppn = 22'h1;
        @(negedge clk);
        miss_i = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h00000801;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mid_l0_req", 64'(mem_req), 64'd1);
        chk("mid_l0_addr", 64'(mem_addr), 64'h200C);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_victim = '0;
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0001404B;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_quiet", 64'({tlb_we, fault, mem_req, busy}), 64'd0);
        @(negedge clk);
        chk("late_ack_quiet2", 64'({tlb_we, fault, mem_req, busy}), 64'd0);
        walk(vecs[0], 1'b0);

        // Victim wrap from a clean reset, miss_i held high while busy
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_victim = '0;
        for (int i = 0; i < 33; i++) walk(vecs[0], 1'b1);
        chk("wrap_victim_model", 64'(m_victim), 64'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_quiet", 64'({mem_req, busy}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
